// File: rtl/turn_scheduler.sv
// turn_scheduler: decides whether the local or the remote player owns the turn.
// Holds the local turn until the throw window closes and the projectile lands.
// Then it hands the turn to the remote side until the link reports the remote
// throw complete. It also applies a local turn timeout and a game-over lockout.
//
// state          | meaning
// ---------------+----------------------------------------------------------
// S_IDLE         | no game running, waiting for start
// S_LOCAL_TURN   | local player owns the turn, timeout counter running
// S_LOCAL_FLIGHT | local throw released, waiting for the projectile to land
// S_HANDOFF      | fixed pause between turns, next_local picks the successor
// S_REMOTE_TURN  | remote player owns the turn, waiting for remote_done
// S_GAME_OVER    | lockout, all turn outputs low, turn_count frozen
module turn_scheduler #(
  parameter int unsigned TURN_TIMEOUT  = 650000000,
  parameter int unsigned HANDOFF_DELAY = 65000000,
  parameter bit          LOCAL_FIRST   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       game_over,
  input  logic       throw_enable,
  input  logic       local_landed,
  input  logic       remote_done,
  output logic       whose_turn,
  output logic       remote_turn,
  output logic       turn_timeout,
  output logic [7:0] turn_count,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_LOCAL_TURN   = 3'd1,
    S_LOCAL_FLIGHT = 3'd2,
    S_HANDOFF      = 3'd3,
    S_REMOTE_TURN  = 3'd4,
    S_GAME_OVER    = 3'd5
  } state_t;

  localparam logic [31:0] TIMEOUT_LAST = 32'(TURN_TIMEOUT - 1);
  localparam logic [31:0] HANDOFF_LAST = 32'(HANDOFF_DELAY - 1);
  localparam state_t      FIRST_TURN   = LOCAL_FIRST ? S_LOCAL_TURN : S_REMOTE_TURN;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] counter;
  logic        throw_prev;
  logic        throw_fall;
  logic        next_local;
  logic        next_local_nxt;
  logic        timeout_nxt;
  logic        state_change;
  logic        game_restart;
  logic        handoff_entry;

  // throw_prev only ever holds a value sampled while staying in LOCAL_TURN,
  // so a falling edge that began elsewhere can never be seen here.
  assign throw_fall    = throw_prev & ~throw_enable;
  assign state_change  = (state_nxt != state);
  assign game_restart  = state_change &&
                         ((state == S_IDLE) || (state == S_GAME_OVER)) &&
                         (state_nxt != S_GAME_OVER);
  assign handoff_entry = state_change && (state_nxt == S_HANDOFF);

  // Next-state decode: game_over overrides everything, then the state's own
  // event, then the local timeout (a throw edge beats a coincident timeout).
  always_comb begin
    state_nxt      = state;
    next_local_nxt = next_local;
    timeout_nxt    = 1'b0;
    if (game_over) begin
      state_nxt = S_GAME_OVER;
    end else begin
      case (state)
        S_IDLE, S_GAME_OVER: begin
          if (start) state_nxt = FIRST_TURN;
        end
        S_LOCAL_TURN: begin
          if (throw_fall) begin
            state_nxt = S_LOCAL_FLIGHT;
          end else if (counter == TIMEOUT_LAST) begin
            state_nxt      = S_HANDOFF;
            next_local_nxt = 1'b0;
            timeout_nxt    = 1'b1;
          end
        end
        S_LOCAL_FLIGHT: begin
          if (local_landed) begin
            state_nxt      = S_HANDOFF;
            next_local_nxt = 1'b0;
          end
        end
        S_HANDOFF: begin
          if (counter == HANDOFF_LAST) begin
            state_nxt = next_local ? S_LOCAL_TURN : S_REMOTE_TURN;
          end
        end
        S_REMOTE_TURN: begin
          if (remote_done) begin
            state_nxt      = S_HANDOFF;
            next_local_nxt = 1'b1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // State register plus outputs registered from the next state, so they are
  // valid in the first cycle of the new state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      next_local   <= 1'b0;
      whose_turn   <= 1'b0;
      remote_turn  <= 1'b0;
      turn_timeout <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      next_local   <= next_local_nxt;
      whose_turn   <= (state_nxt == S_LOCAL_TURN);
      remote_turn  <= (state_nxt == S_REMOTE_TURN);
      turn_timeout <= timeout_nxt;
      busy         <= (state_nxt != S_IDLE) && (state_nxt != S_GAME_OVER);
    end
  end

  // Shared timeout/handoff counter and throw edge register; both restart on
  // every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter    <= 32'd0;
      throw_prev <= 1'b0;
    end else begin
      if (state_change) begin
        counter <= 32'd0;
      end else if ((state == S_LOCAL_TURN) || (state == S_HANDOFF)) begin
        counter <= counter + 32'd1;
      end else begin
        counter <= 32'd0;
      end
      throw_prev <= (!state_change && (state == S_LOCAL_TURN)) ? throw_enable : 1'b0;
    end
  end

  // Completed-turn count: cleared when a game starts, saturating increment on
  // each entry to HANDOFF, frozen otherwise (including in GAME_OVER).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      turn_count <= 8'd0;
    end else if (game_restart) begin
      turn_count <= 8'd0;
    end else if (handoff_entry && (turn_count != 8'hFF)) begin
      turn_count <= turn_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_turn_scheduler.sv
// Directed bench for turn_scheduler: stimulus pushes the expected post-edge
// outputs into a queue; a monitor pops and compares one entry per clock edge.
module tb_turn_scheduler;

  localparam int TT = 20;
  localparam int HD = 3;

  // expected {whose_turn, remote_turn, turn_timeout, busy}
  localparam logic [3:0] O_IDLE = 4'b0000;
  localparam logic [3:0] O_LT   = 4'b1001;
  localparam logic [3:0] O_FL   = 4'b0001;
  localparam logic [3:0] O_HO   = 4'b0001;
  localparam logic [3:0] O_TO   = 4'b0011;
  localparam logic [3:0] O_RT   = 4'b0101;
  localparam logic [3:0] O_GO   = 4'b0000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       game_over = 1'b0;
  logic       throw_enable = 1'b0;
  logic       local_landed = 1'b0;
  logic       remote_done = 1'b0;
  logic       whose_turn;
  logic       remote_turn;
  logic       turn_timeout;
  logic [7:0] turn_count;
  logic       busy;

  typedef struct {
    string      name;
    logic [3:0] outs;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   exp_cnt;

  always #5 clk = ~clk;

  turn_scheduler #(
    .TURN_TIMEOUT (TT),
    .HANDOFF_DELAY(HD),
    .LOCAL_FIRST  (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .game_over   (game_over),
    .throw_enable(throw_enable),
    .local_landed(local_landed),
    .remote_done (remote_done),
    .whose_turn  (whose_turn),
    .remote_turn (remote_turn),
    .turn_timeout(turn_timeout),
    .turn_count  (turn_count),
    .busy        (busy)
  );

  task automatic compare(input string nm, input logic [3:0] outs, input logic [7:0] cnt);
    n_checks++;
    if ({whose_turn, remote_turn, turn_timeout, busy} !== outs || turn_count !== cnt) begin
      n_fail++;
      $display("FAIL %s: got w/r/t/b=%b count=%0d, required w/r/t/b=%b count=%0d",
               nm, {whose_turn, remote_turn, turn_timeout, busy}, turn_count, outs, cnt);
    end
  endtask

  // Queue the outputs expected after the coming edge, apply it, drop pulses.
  task automatic tick(input string nm, input logic [3:0] outs, input int cnt);
    exp_t e;
    e.name = nm;
    e.outs = outs;
    e.cnt  = 8'(cnt);
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    start        = 1'b0;
    local_landed = 1'b0;
    remote_done  = 1'b0;
  endtask

  // Monitor: one expectation per edge, sampled 1 time unit after it.
  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      compare(mon_e.name, mon_e.outs, mon_e.cnt);
    end
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    tick("reset", O_IDLE, 0);
    rst = 1'b0;
    tick("idle", O_IDLE, 0);

    // full local turn
    start = 1'b1;
    tick("s1_start", O_LT, 0);
    throw_enable = 1'b1;
    repeat (5) tick("s1_throw_high", O_LT, 0);
    throw_enable = 1'b0;
    tick("s1_throw_fall", O_FL, 0);
    remote_done = 1'b1;
    tick("s1_flight_stray_rdone", O_FL, 0);
    start = 1'b1;
    tick("s1_flight_stray_start", O_FL, 0);
    tick("s1_flight", O_FL, 0);
    local_landed = 1'b1;
    tick("s1_land", O_HO, 1);
    repeat (2) tick("s1_handoff", O_HO, 1);
    tick("s1_remote", O_RT, 1);

    // round trip back to local, stale and stray events ignored
    local_landed = 1'b1;
    tick("s3_remote_stray_land", O_RT, 1);
    remote_done  = 1'b1;
    throw_enable = 1'b1;
    tick("s3_done", O_HO, 2);
    repeat (2) tick("s3_handoff", O_HO, 2);
    tick("s3_local", O_LT, 2);
    throw_enable = 1'b0;
    tick("s3_stale_edge", O_LT, 2);
    remote_done = 1'b1;
    tick("s3_stray_rdone", O_LT, 2);
    local_landed = 1'b1;
    tick("s3_stray_land", O_LT, 2);
    throw_enable = 1'b1;
    tick("s3_throw_high", O_LT, 2);
    throw_enable = 1'b0;
    tick("s3_throw_fall", O_FL, 2);

    // game over during flight, start ignored while game_over high
    game_over = 1'b1;
    tick("s4_game_over", O_GO, 2);
    tick("s4_hold", O_GO, 2);
    start = 1'b1;
    tick("s4_start_ignored", O_GO, 2);
    game_over = 1'b0;
    tick("s4_release", O_GO, 2);
    start = 1'b1;
    tick("s4_restart", O_LT, 0);

    // local timeout: whose_turn high for exactly TT cycles
    repeat (19) tick("s2_local", O_LT, 0);
    tick("s2_timeout", O_TO, 1);
    repeat (2) tick("s2_handoff", O_HO, 1);
    tick("s2_remote", O_RT, 1);

    // throw edge coincident with the last timeout cycle
    remote_done = 1'b1;
    tick("s5_done", O_HO, 2);
    repeat (2) tick("s5_handoff", O_HO, 2);
    tick("s5_local", O_LT, 2);
    throw_enable = 1'b1;
    repeat (19) tick("s5_throw_high", O_LT, 2);
    throw_enable = 1'b0;
    tick("s5_simultaneous", O_FL, 2);
    tick("s5_flight", O_FL, 2);
    local_landed = 1'b1;
    tick("s5_land", O_HO, 3);
    tick("s5_handoff", O_HO, 3);

    // asynchronous reset mid-handoff
    #2;
    rst = 1'b1;
    #1;
    compare("s5_async_reset", O_IDLE, 0);
    @(negedge clk);
    tick("s5_reset_hold", O_IDLE, 0);
    rst = 1'b0;
    tick("s5_idle", O_IDLE, 0);

    // 260 turns: turn_count saturates
    start   = 1'b1;
    exp_cnt = 0;
    tick("sat_start", O_LT, exp_cnt);
    for (int i = 0; i < 130; i++) begin
      throw_enable = 1'b1;
      tick("sat_throw_high", O_LT, exp_cnt);
      throw_enable = 1'b0;
      tick("sat_flight", O_FL, exp_cnt);
      local_landed = 1'b1;
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      tick("sat_handoff_l", O_HO, exp_cnt);
      repeat (2) tick("sat_handoff_l", O_HO, exp_cnt);
      tick("sat_remote", O_RT, exp_cnt);
      remote_done = 1'b1;
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      tick("sat_handoff_r", O_HO, exp_cnt);
      repeat (2) tick("sat_handoff_r", O_HO, exp_cnt);
      tick("sat_local", O_LT, exp_cnt);
    end
    tick("sat_final", O_LT, 255);

    @(negedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/turn_scheduler.md
# turn_scheduler

Turn scheduler for the two-player game. It decides whether the local or the remote player owns the turn, and drives `whose_turn` into the local turn FSM. It holds the turn until the local throw window closes and the projectile lands, then hands the turn to the remote player until the link reports the remote throw complete. It also enforces a local turn timeout and a game-over lockout, and sits between game-state logic, the local turn FSM and the UART link receiver.

## Interface
Parameters:
- TURN_TIMEOUT, 650000000: cycles allowed in LOCAL_TURN without a throw (10 s at 65 MHz); must be ≥ 2.
- HANDOFF_DELAY, 65000000: cycles spent in HANDOFF between turns; must be ≥ 1.
- LOCAL_FIRST, 1: 1 means the local player takes the first turn after `start`; 0 means the remote player does.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a game; honoured only in IDLE or GAME_OVER.
- game_over  input  1  level from game logic; forces GAME_OVER from any state.
- throw_enable  input  1  throw window output of the local turn FSM.
- local_landed  input  1  single-cycle pulse when the local projectile's flight ends.
- remote_done  input  1  single-cycle pulse from the link when the remote turn is finished.
- whose_turn  output  1  high only in LOCAL_TURN; feeds the local turn FSM.
- remote_turn  output  1  high only in REMOTE_TURN.
- turn_timeout  output  1  single-cycle pulse when a local turn expires.
- turn_count  output  8  completed turns, saturating at 255.
- busy  output  1  high in every state except IDLE and GAME_OVER.

## Operation
- States: IDLE, LOCAL_TURN, LOCAL_FLIGHT, HANDOFF, REMOTE_TURN, GAME_OVER. A single 32-bit counter is shared by the timeout and the handoff delay.
- IDLE
  - On `start`: enter LOCAL_TURN if LOCAL_FIRST=1, else REMOTE_TURN.
  - Clear turn_count and the counter.
- LOCAL_TURN
  - Counter increments every cycle.
  - On a falling edge of `throw_enable` (registered previous value is 1, current value is 0): enter LOCAL_FLIGHT.
  - Otherwise, when counter = TURN_TIMEOUT−1: pulse turn_timeout and enter HANDOFF with next = REMOTE.
  - A falling edge that does not start inside LOCAL_TURN is ignored. The edge register is cleared on entry to LOCAL_TURN.
- LOCAL_FLIGHT
  - `whose_turn` is 0.
  - On `local_landed`: enter HANDOFF with next = REMOTE. No timeout applies.
- HANDOFF
  - Counter counts to HANDOFF_DELAY−1, then enter the `next` state.
  - turn_count increments, saturating, on every entry to HANDOFF.
- REMOTE_TURN
  - On `remote_done`: enter HANDOFF with next = LOCAL.
- GAME_OVER
  - All turn outputs are 0. turn_count holds its value.
  - On `start` with game_over low: behave as `start` from IDLE, including clearing turn_count.
- Event priority, highest first:
  1. `rst`
  2. `game_over` (entered from any state on the next edge)
  3. the state-specific event
  4. timeout
- A throw edge and the timeout arriving in the same cycle resolve to LOCAL_FLIGHT, with no timeout pulse.
- Pulses that arrive outside their owning state are dropped; they are not latched.
- The counter resets to 0 on every state change.

## Timing
- All outputs are registered and reflect the current state one cycle after the transition edge.
- Reset values:
  - state = IDLE
  - whose_turn = 0, remote_turn = 0, turn_timeout = 0, busy = 0
  - turn_count = 0, counter = 0, edge register = 0
- Cycle counts:
  - `start` to whose_turn=1: 1 cycle.
  - Local timeout: whose_turn falls exactly TURN_TIMEOUT cycles after it rose. turn_timeout is high for that 1 cycle.
  - HANDOFF: exactly HANDOFF_DELAY cycles with both whose_turn and remote_turn low.
  - `throw_enable` falling to whose_turn low: 1 cycle.
- When whose_turn drops, the local FSM returns to IDLE. The local throw window therefore completes before whose_turn is removed.
- `rst` mid-turn forces IDLE immediately (asynchronous); outputs go to their reset values without waiting for a clock edge.

## Test plan
Bench parameters for all scenarios: TURN_TIMEOUT=20, HANDOFF_DELAY=3, LOCAL_FIRST=1.
1. Full local turn:
   - Stimulus: `start`; `throw_enable` high for 5 cycles, then low; `local_landed` 4 cycles later.
   - Required: whose_turn high from cycle 1 until 1 cycle after the throw falls; then 3 HANDOFF cycles; remote_turn=1; turn_count=1.
2. Local timeout:
   - Stimulus: `start`; no throw.
   - Required: turn_timeout pulses for exactly 1 cycle when whose_turn falls after 20 cycles; remote_turn rises 3 cycles later; turn_count=1.
3. Round trip:
   - Stimulus: after scenario 1, `remote_done`.
   - Required: 3 HANDOFF cycles; whose_turn=1; turn_count=2. Stray `remote_done` and `local_landed` pulses during LOCAL_TURN are ignored.
4. Game over and restart:
   - Stimulus: assert game_over during LOCAL_FLIGHT; then `start` with game_over still high; then `start` with game_over low.
   - Required: GAME_OVER on the next edge with all outputs low and turn_count held; the first `start` is ignored; the second restarts with turn_count=0.
5. Edge cases:
   - Stimulus: a throw falling edge in the same cycle as counter=19 (simultaneous throw and timeout); separately, `rst` asserted mid-HANDOFF; separately, 260 turns.
   - Required: LOCAL_FLIGHT with no turn_timeout pulse; all outputs 0 asynchronously on reset; turn_count saturates at 255.
